regfile_wb_arbiter: RTL and testbench

//  Owns the RegisterFile write port and tracks pending multiplier results in mul_cpu.

---
 rtl/regfile_wb_arbiter.sv | 129 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: merges single-cycle ALU results and buffered
// multiplier results onto one write port, and keeps a busy scoreboard for
// registers that are waiting on an issued multiply.
module regfile_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int NREGS      = 32,
  parameter int FIFO_DEPTH = 2,
  localparam int CW        = $clog2(FIFO_DEPTH + 1),
  localparam int PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_wb_valid,
  output logic              alu_wb_ready,
  input  logic [ADDR_W-1:0] alu_wb_reg,
  input  logic [DATA_W-1:0] alu_wb_data,
  input  logic              mul_issue_valid,
  output logic              mul_issue_ready,
  input  logic [ADDR_W-1:0] mul_issue_reg,
  input  logic              mul_wb_valid,
  output logic              mul_wb_ready,
  input  logic [ADDR_W-1:0] mul_wb_reg,
  input  logic [DATA_W-1:0] mul_wb_data,
  input  logic              rd1_en,
  input  logic              rd2_en,
  input  logic [ADDR_W-1:0] rd1_reg,
  input  logic [ADDR_W-1:0] rd2_reg,
  output logic              hazard_stall,
  output logic              rf_Regwr,
  output logic [ADDR_W-1:0] rf_w_Reg,
  output logic [DATA_W-1:0] rf_w_data,
  output logic [NREGS-1:0]  busy_vec,
  output logic [CW-1:0]     fifo_count,
  output logic              wb_err
);

  typedef struct packed {
    logic [ADDR_W-1:0] rg;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t              fifo_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic [NREGS-1:0]  busy_q, busy_d;
  logic              regwr_q;
  logic [ADDR_W-1:0] wreg_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;

  logic full, empty, pop, enq, alu_fire, issue_fire;
  ent_t head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Arbitration, handshakes and scoreboard next state.
  always_comb begin
    full       = (count_q == CW'(FIFO_DEPTH));
    empty      = (count_q == '0);
    head       = fifo_q[rd_ptr_q];
    // A full FIFO must drain before the ALU may write again.
    pop        = !empty && (full || !alu_wb_valid);
    alu_fire   = alu_wb_valid && !full;
    enq        = mul_wb_valid && !full;
    issue_fire = mul_issue_valid && !busy_q[mul_issue_reg];
    count_d    = count_q + CW'(enq) - CW'(pop);
    busy_d     = busy_q;
    if (pop) busy_d[head.rg] = 1'b0;
    // A reg being popped is still busy here, so issue to it was already rejected.
    if (issue_fire && mul_issue_reg != '0) busy_d[mul_issue_reg] = 1'b1;
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (enq) begin
        fifo_q[wr_ptr_q] <= '{rg: mul_wb_reg, data: mul_wb_data};
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
    end
  end

  // Registered write port, scoreboard and sticky protocol error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwr_q <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      regwr_q <= 1'b0;
      if (pop) begin
        regwr_q <= (head.rg != '0);
        wreg_q  <= head.rg;
        wdata_q <= head.data;
      end else if (alu_fire) begin
        regwr_q <= (alu_wb_reg != '0);
        wreg_q  <= alu_wb_reg;
        wdata_q <= alu_wb_data;
      end
      busy_q <= busy_d;
      if (enq && mul_wb_reg != '0 && !busy_q[mul_wb_reg]) err_q <= 1'b1;
    end
  end

  assign alu_wb_ready    = !full;
  assign mul_wb_ready    = !full;
  assign mul_issue_ready = !busy_q[mul_issue_reg];
  assign hazard_stall    = (rd1_en && busy_q[rd1_reg]) || (rd2_en && busy_q[rd2_reg]) ||
                           (alu_wb_valid && busy_q[alu_wb_reg]) || (alu_wb_valid && full);
  assign rf_Regwr        = regwr_q;
  assign rf_w_Reg        = wreg_q;
  assign rf_w_data       = wdata_q;
  assign busy_vec        = busy_q;
  assign fifo_count      = count_q;
  assign wb_err          = err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with hand-computed expectations.
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        alu_wb_valid, alu_wb_ready;
  logic [4:0]  alu_wb_reg;
  logic [31:0] alu_wb_data;
  logic        mul_issue_valid, mul_issue_ready;
  logic [4:0]  mul_issue_reg;
  logic        mul_wb_valid, mul_wb_ready;
  logic [4:0]  mul_wb_reg;
  logic [31:0] mul_wb_data;
  logic        rd1_en, rd2_en;
  logic [4:0]  rd1_reg, rd2_reg;
  logic        hazard_stall, rf_Regwr;
  logic [4:0]  rf_w_Reg;
  logic [31:0] rf_w_data;
  logic [31:0] busy_vec;
  logic [1:0]  fifo_count;
  logic        wb_err;

  int errs = 0, checks = 0;

  regfile_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready),
    .alu_wb_reg(alu_wb_reg), .alu_wb_data(alu_wb_data),
    .mul_issue_valid(mul_issue_valid), .mul_issue_ready(mul_issue_ready),
    .mul_issue_reg(mul_issue_reg),
    .mul_wb_valid(mul_wb_valid), .mul_wb_ready(mul_wb_ready),
    .mul_wb_reg(mul_wb_reg), .mul_wb_data(mul_wb_data),
    .rd1_en(rd1_en), .rd2_en(rd2_en), .rd1_reg(rd1_reg), .rd2_reg(rd2_reg),
    .hazard_stall(hazard_stall), .rf_Regwr(rf_Regwr), .rf_w_Reg(rf_w_Reg),
    .rf_w_data(rf_w_data), .busy_vec(busy_vec), .fifo_count(fifo_count),
    .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    alu_wb_valid = 0; alu_wb_reg = 0; alu_wb_data = 0;
    mul_issue_valid = 0; mul_issue_reg = 0;
    mul_wb_valid = 0; mul_wb_reg = 0; mul_wb_data = 0;
    rd1_en = 0; rd2_en = 0; rd1_reg = 0; rd2_reg = 0;
  endtask

  initial begin
    idle();
    #12;
    chk("rst_regwr", rf_Regwr, 0);
    chk("rst_busy", busy_vec, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_err", wb_err, 0);
    rst_n = 1;
    tick();

    // ALU write r5
    alu_wb_valid = 1; alu_wb_reg = 5; alu_wb_data = 32'hDEADBEEF; #1;
    chk("alu_ready", alu_wb_ready, 1);
    chk("alu_nostall", hazard_stall, 0);
    tick(); idle();
    chk("alu_regwr", rf_Regwr, 1);
    chk("alu_wreg", rf_w_Reg, 5);
    chk("alu_wdata", rf_w_data, 32'hDEADBEEF);
    tick();
    chk("alu_regwr_off", rf_Regwr, 0);
    chk("alu_wdata_hold", rf_w_data, 32'hDEADBEEF);

    // Mul path r7
    mul_issue_valid = 1; mul_issue_reg = 7; #1;
    chk("iss7_ready", mul_issue_ready, 1);
    tick(); idle();
    chk("iss7_busy", busy_vec, 32'h80);
    rd1_en = 1; rd1_reg = 7; #1;
    chk("rd7_stall", hazard_stall, 1);
    mul_wb_valid = 1; mul_wb_reg = 7; mul_wb_data = 32'h12; #1;
    chk("mwb7_ready", mul_wb_ready, 1);
    tick(); mul_wb_valid = 0; #1;
    chk("mwb7_count", fifo_count, 1);
    chk("mwb7_busy_n1", busy_vec, 32'h80);
    chk("mwb7_stall_n1", hazard_stall, 1);
    chk("mwb7_regwr_n1", rf_Regwr, 0);
    tick();
    chk("mwb7_regwr", rf_Regwr, 1);
    chk("mwb7_wreg", rf_w_Reg, 7);
    chk("mwb7_wdata", rf_w_data, 32'h12);
    chk("mwb7_busy", busy_vec, 0);
    chk("mwb7_stall", hazard_stall, 0);
    chk("mwb7_count0", fifo_count, 0);
    chk("mwb7_err", wb_err, 0);
    idle();

    // Contention: reserve r10, r11
    mul_issue_valid = 1; mul_issue_reg = 10; tick();
    mul_issue_reg = 11; tick(); idle();
    chk("cont_busy", busy_vec, 32'hC00);
    alu_wb_valid = 1; alu_wb_reg = 1; alu_wb_data = 32'h101;
    mul_wb_valid = 1; mul_wb_reg = 10; mul_wb_data = 32'hA0;
    tick();
    chk("c0_wreg", rf_w_Reg, 1);
    chk("c0_count", fifo_count, 1);
    alu_wb_reg = 2; alu_wb_data = 32'h102;
    mul_wb_reg = 11; mul_wb_data = 32'hB0; #1;
    chk("c1_alu_ready", alu_wb_ready, 1);
    tick();
    chk("c1_wreg", rf_w_Reg, 2);
    chk("c1_wdata", rf_w_data, 32'h102);
    chk("c1_count", fifo_count, 2);
    alu_wb_reg = 3; alu_wb_data = 32'h103; mul_wb_valid = 0; #1;
    chk("c2_alu_ready", alu_wb_ready, 0);
    chk("c2_mul_ready", mul_wb_ready, 0);
    chk("c2_stall", hazard_stall, 1);
    tick();
    chk("c2_wreg", rf_w_Reg, 10);
    chk("c2_wdata", rf_w_data, 32'hA0);
    chk("c2_count", fifo_count, 1);
    chk("c2_busy", busy_vec, 32'h800);
    chk("c3_alu_ready", alu_wb_ready, 1);
    tick(); alu_wb_valid = 0;
    chk("c3_wreg", rf_w_Reg, 3);
    chk("c3_wdata", rf_w_data, 32'h103);
    tick(); idle();
    chk("c4_regwr", rf_Regwr, 1);
    chk("c4_wreg", rf_w_Reg, 11);
    chk("c4_wdata", rf_w_data, 32'hB0);
    chk("c4_count", fifo_count, 0);
    chk("c4_busy", busy_vec, 0);

    // Reg 0 and duplicate issue
    mul_issue_valid = 1; mul_issue_reg = 0; #1;
    chk("iss0_ready", mul_issue_ready, 1);
    tick(); idle();
    chk("iss0_busy", busy_vec, 0);
    mul_wb_valid = 1; mul_wb_reg = 0; mul_wb_data = 32'h5; tick(); idle();
    tick();
    chk("mwb0_regwr", rf_Regwr, 0);
    chk("mwb0_err", wb_err, 0);
    mul_issue_valid = 1; mul_issue_reg = 9; tick();
    #1;
    chk("iss9_dup_ready", mul_issue_ready, 0);
    tick(); idle();
    chk("iss9_busy", busy_vec, 32'h200);
    alu_wb_valid = 1; alu_wb_reg = 9; #1;
    chk("waw9_stall", hazard_stall, 1);
    idle();
    mul_wb_valid = 1; mul_wb_reg = 9; mul_wb_data = 32'h99; tick(); idle();
    tick();
    chk("mwb9_wreg", rf_w_Reg, 9);
    chk("mwb9_busy", busy_vec, 0);

    // Protocol error
    mul_wb_valid = 1; mul_wb_reg = 3; mul_wb_data = 32'h33; tick(); idle();
    chk("err_set", wb_err, 1);
    tick();
    chk("err_regwr", rf_Regwr, 1);
    chk("err_wreg", rf_w_Reg, 3);
    chk("err_wdata", rf_w_data, 32'h33);
    tick(); tick();
    chk("err_sticky", wb_err, 1);

    // Async reset mid-write
    mul_issue_valid = 1; mul_issue_reg = 12; tick(); idle();
    alu_wb_valid = 1; alu_wb_reg = 4; alu_wb_data = 32'h44;
    mul_wb_valid = 1; mul_wb_reg = 12; mul_wb_data = 32'hC0;
    tick(); idle();
    chk("pre_rst_regwr", rf_Regwr, 1);
    chk("pre_rst_count", fifo_count, 1);
    #1 rst_n = 0; #1;
    chk("arst_regwr", rf_Regwr, 0);
    chk("arst_busy", busy_vec, 0);
    chk("arst_count", fifo_count, 0);
    chk("arst_err", wb_err, 0);
    chk("arst_wdata", rf_w_data, 0);
    tick(); rst_n = 1; tick();
    chk("post_rst_regwr", rf_Regwr, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
